axi4_lite_reg_bridge: RTL and testbench

- AXI4-Lite slave front end that converts host MMIO transactions into the simple valid/ack register request interface consumed by the dispatcher register configuration block.
- Sits directly upstream of that block. Drives write address/data/valid and read address/valid; consumes write ack, read data and read ack.
- Independent write and read engines, each with a timeout so that a target that never acks cannot hang the AXI bus.

---
 rtl/axi4_lite_reg_bridge.sv | 246 ++++++++++++++++++++++++
 tb/tb_axi4_lite_reg_bridge.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_reg_bridge.sv
// AXI4-Lite slave that turns host MMIO accesses into valid/ack register requests.
// Write and read engines are independent. Each one aborts with SLVERR if its target never acks.
module axi4_lite_reg_bridge #(
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic [AddressWidth-1:0] AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DataWidth-1:0]    WDATA,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [AddressWidth-1:0] ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DataWidth-1:0]    RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [AddressWidth-1:0] oWriteAddress,
  output logic [DataWidth-1:0]    oWriteData,
  output logic                    oWriteValid,
  input  logic                    iWriteAck,
  output logic [AddressWidth-1:0] oReadAddress,
  output logic                    oReadValid,
  input  logic [DataWidth-1:0]    iReadData,
  input  logic                    iReadAck
);

  localparam logic [1:0]  RespOkay     = 2'b00;
  localparam logic [1:0]  RespSlvErr   = 2'b10;
  localparam logic [16:0] TimeoutLimit = 17'(TimeoutCycles);

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} r_state_e;

  w_state_e                w_state_q, w_state_d;
  logic                    aw_have_q, aw_have_d;
  logic                    w_have_q, w_have_d;
  logic [15:0]             w_cnt_q, w_cnt_d;
  logic [16:0]             w_cnt_inc;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    wreq_q, wreq_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [AddressWidth-1:0] waddr_q, waddr_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;
  logic                    aw_hs, w_hs;

  r_state_e                r_state_q, r_state_d;
  logic [15:0]             r_cnt_q, r_cnt_d;
  logic [16:0]             r_cnt_inc;
  logic                    arready_q, arready_d;
  logic                    rreq_q, rreq_d;
  logic                    rvalid_q, rvalid_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [AddressWidth-1:0] raddr_q, raddr_d;
  logic [DataWidth-1:0]    rdata_q, rdata_d;

  always_comb begin
    w_state_d = w_state_q;
    aw_have_d = aw_have_q;
    w_have_d  = w_have_q;
    w_cnt_d   = w_cnt_q;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    wreq_d    = 1'b0;
    bvalid_d  = 1'b0;
    bresp_d   = bresp_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    aw_hs     = AWVALID && awready_q;
    w_hs      = WVALID && wready_q;
    w_cnt_inc = {1'b0, w_cnt_q} + 17'd1;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          waddr_d   = AWADDR;
          aw_have_d = 1'b1;
        end
        if (w_hs) begin
          wdata_d  = WDATA;
          w_have_d = 1'b1;
        end
        if (aw_have_d && w_have_d) begin
          w_state_d = W_REQ;
          wreq_d    = 1'b1;
          w_cnt_d   = '0;
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
        end else begin
          awready_d = !aw_have_d;
          wready_d  = !w_have_d;
        end
      end
      W_REQ: begin
        // Ack is checked first so that it wins a tie with the timeout.
        if (iWriteAck) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = RespOkay;
        end else if (w_cnt_inc >= TimeoutLimit) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = RespSlvErr;
          w_cnt_d   = TimeoutLimit[15:0];
        end else begin
          wreq_d  = 1'b1;
          w_cnt_d = w_cnt_inc[15:0];
        end
      end
      W_RESP: begin
        if (BREADY) begin
          w_state_d = W_IDLE;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      w_state_q <= W_IDLE;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      w_cnt_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      wreq_q    <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_have_q <= aw_have_d;
      w_have_q  <= w_have_d;
      w_cnt_q   <= w_cnt_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      wreq_q    <= wreq_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    arready_d = 1'b0;
    rreq_d    = 1'b0;
    rvalid_d  = 1'b0;
    rresp_d   = rresp_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    r_cnt_inc = {1'b0, r_cnt_q} + 17'd1;
    case (r_state_q)
      R_IDLE: begin
        if (ARVALID && arready_q) begin
          raddr_d   = ARADDR;
          r_state_d = R_REQ;
          rreq_d    = 1'b1;
          r_cnt_d   = '0;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_REQ: begin
        if (iReadAck) begin
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
          rdata_d   = iReadData;
          rresp_d   = RespOkay;
        end else if (r_cnt_inc >= TimeoutLimit) begin
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
          rdata_d   = '0;
          rresp_d   = RespSlvErr;
          r_cnt_d   = TimeoutLimit[15:0];
        end else begin
          rreq_d  = 1'b1;
          r_cnt_d = r_cnt_inc[15:0];
        end
      end
      R_RESP: begin
        if (RREADY) begin
          r_state_d = R_IDLE;
          arready_d = 1'b1;
        end else begin
          rvalid_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      arready_q <= 1'b0;
      rreq_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      raddr_q   <= '0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      arready_q <= arready_d;
      rreq_q    <= rreq_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
    end
  end

  assign AWREADY       = awready_q;
  assign WREADY        = wready_q;
  assign BVALID        = bvalid_q;
  assign BRESP         = bresp_q;
  assign oWriteAddress = waddr_q;
  assign oWriteData    = wdata_q;
  assign oWriteValid   = wreq_q;
  assign ARREADY       = arready_q;
  assign RVALID        = rvalid_q;
  assign RRESP         = rresp_q;
  assign RDATA         = rdata_q;
  assign oReadAddress  = raddr_q;
  assign oReadValid    = rreq_q;

endmodule

// File: tb/tb_axi4_lite_reg_bridge.sv
// Bench for axi4_lite_reg_bridge: directed and randomized write/read transactions.
// Expected behaviour comes from a transaction-level model (request length, response code, payload).
module tb_axi4_lite_reg_bridge;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA, iReadData;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] oWriteAddress, oWriteData, oReadAddress;
  logic        oWriteValid, iWriteAck, oReadValid, iReadAck;

  int n_tests = 0;
  int n_fail  = 0;

  axi4_lite_reg_bridge #(
    .AddressWidth(32), .DataWidth(32), .TimeoutCycles(T)
  ) dut (
    .iClock(clk), .iReset(rst),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .oWriteAddress(oWriteAddress), .oWriteData(oWriteData), .oWriteValid(oWriteValid),
    .iWriteAck(iWriteAck),
    .oReadAddress(oReadAddress), .oReadValid(oReadValid),
    .iReadData(iReadData), .iReadAck(iReadAck)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ctrl_zero"},
        {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, oWriteValid, oReadValid}, 0);
    chk({tag, "_rdata_zero"}, RDATA, 0);
    chk({tag, "_waddr_zero"}, oWriteAddress, 0);
    chk({tag, "_wdata_zero"}, oWriteData, 0);
    chk({tag, "_raddr_zero"}, oReadAddress, 0);
  endtask

  // ack_dly: request cycle (0 = first) in which the target acks; -1 = never.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input int aw_dly, input int w_dly, input int ack_dly, input int b_dly);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w, ready_ok = 1, stable = 1, bstable = 1, ok;
    int c = 0, n = 0, exp_n;
    logic [1:0] exp_resp;
    ok       = (ack_dly >= 0) && (ack_dly < T);
    exp_n    = ok ? ack_dly + 1 : T;
    exp_resp = ok ? 2'b00 : 2'b10;
    while (!(aw_done && w_done) && c < 40) begin
      AWVALID = !aw_done && (c >= aw_dly);
      AWADDR  = AWVALID ? addr : $urandom;
      WVALID  = !w_done && (c >= w_dly);
      WDATA   = WVALID ? data : $urandom;
      hs_aw   = AWVALID && AWREADY;
      hs_w    = WVALID && WREADY;
      if ((aw_done && AWREADY) || (w_done && WREADY)) ready_ok = 0;
      tick();
      aw_done = aw_done || hs_aw;
      w_done  = w_done || hs_w;
      c++;
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    chk("wr_handshakes_done", aw_done && w_done, 1);
    chk("wr_ready_drop", ready_ok, 1);
    chk("wr_req_latency", oWriteValid, 1);
    chk("wr_ready_in_req", {AWREADY, WREADY}, 0);
    while (oWriteValid && n < T + 4) begin
      if (oWriteAddress !== addr || oWriteData !== data) stable = 0;
      iWriteAck = (n == ack_dly);
      BREADY    = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    iWriteAck = 1'b0;
    BREADY    = 1'b0;
    chk("wr_valid_cycles", n, exp_n);
    chk("wr_payload_stable", stable, 1);
    chk("wr_bvalid", BVALID, 1);
    chk("wr_bresp", BRESP, exp_resp);
    for (int i = 0; i < b_dly; i++) begin
      iWriteAck = 1'($urandom_range(0, 1));
      tick();
      if (!BVALID || BRESP !== exp_resp || oWriteValid) bstable = 0;
    end
    chk("wr_b_hold", bstable, 1);
    iWriteAck = 1'b0;
    BREADY    = 1'b1;
    tick();
    BREADY    = 1'b0;
    chk("wr_b_done", {BVALID, AWREADY, WREADY, oWriteValid}, 4'b0110);
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int ack_dly,
                         input logic [31:0] data, input int r_dly);
    bit done = 0, hs, stable = 1, rstable = 1, ok;
    int c = 0, n = 0, exp_n;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    ok       = (ack_dly >= 0) && (ack_dly < T);
    exp_n    = ok ? ack_dly + 1 : T;
    exp_resp = ok ? 2'b00 : 2'b10;
    exp_data = ok ? data : 32'h0;
    while (!done && c < 40) begin
      ARVALID = (c >= ar_dly);
      ARADDR  = ARVALID ? addr : $urandom;
      hs      = ARVALID && ARREADY;
      tick();
      done = hs;
      c++;
    end
    ARVALID = 1'b0;
    chk("rd_handshake_done", done, 1);
    chk("rd_req_latency", oReadValid, 1);
    chk("rd_arready_in_req", ARREADY, 0);
    while (oReadValid && n < T + 4) begin
      if (oReadAddress !== addr) stable = 0;
      iReadAck  = (n == ack_dly);
      iReadData = (n == ack_dly) ? data : $urandom;
      RREADY    = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    iReadAck = 1'b0;
    RREADY   = 1'b0;
    chk("rd_valid_cycles", n, exp_n);
    chk("rd_addr_stable", stable, 1);
    chk("rd_rvalid", RVALID, 1);
    chk("rd_rresp", RRESP, exp_resp);
    chk("rd_rdata", RDATA, exp_data);
    for (int i = 0; i < r_dly; i++) begin
      iReadAck  = 1'($urandom_range(0, 1));
      iReadData = $urandom;
      tick();
      if (!RVALID || RDATA !== exp_data || RRESP !== exp_resp || oReadValid) rstable = 0;
    end
    chk("rd_r_hold", rstable, 1);
    iReadAck = 1'b0;
    RREADY   = 1'b1;
    tick();
    RREADY   = 1'b0;
    chk("rd_r_done", {RVALID, ARREADY, oReadValid}, 3'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin
    bit quiet;
    rst = 1'b1;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    iWriteAck = 1'b0; iReadAck = 1'b0; iReadData = '0;
    repeat (3) tick();
    check_outputs_zero("init");
    rst = 1'b0;
    tick();
    chk("init_ready", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b11100);

    do_write(32'h10, 32'hDEADBEEF, 0, 0, 2, 1);
    do_write(32'h44, 32'hCAFEF00D, 3, 0, 0, 0);
    do_write(32'h80, 32'h0BADF00D, 0, 0, -1, 2);
    do_write(32'h84, 32'h600DF00D, 2, 2, 5, 0);
    do_read(32'h20, 0, 0, 32'h12345678, 4);
    fork
      do_write(32'h90, 32'h55AA55AA, 1, 0, -1, 1);
      do_read(32'h24, 0, 1, 32'hA5A5A5A5, 2);
    join
    fork
      do_write(32'h94, 32'h00000001, 0, 2, T - 1, 0);
      do_read(32'h28, 1, T - 1, 32'h00000077, 0);
    join
    do_read(32'h2C, 0, -1, 32'h00000099, 1);

    for (int it = 0; it < 24; it++) begin
      logic [31:0] wa, wd, ra, rd;
      int awd, wdl, wak, bd, ard, rak, rdl;
      wa  = $urandom; wd = $urandom; ra = $urandom; rd = $urandom;
      awd = int'($urandom_range(0, 3));
      wdl = int'($urandom_range(0, 3));
      wak = int'($urandom_range(0, T + 2)) - 1;
      bd  = int'($urandom_range(0, 3));
      ard = int'($urandom_range(0, 3));
      rak = int'($urandom_range(0, T + 2)) - 1;
      rdl = int'($urandom_range(0, 3));
      fork
        do_write(wa, wd, awd, wdl, wak, bd);
        do_read(ra, ard, rak, rd, rdl);
      join
    end

    // Reset with the write engine requesting and the read engine holding a response.
    AWVALID = 1'b1; AWADDR = 32'h30; WVALID = 1'b1; WDATA = 32'h13579BDF;
    ARVALID = 1'b1; ARADDR = 32'h34;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    iReadAck = 1'b1; iReadData = 32'h2468ACE0;
    tick();
    iReadAck = 1'b0;
    chk("rst_pre_state", {oWriteValid, RVALID, RDATA}, {2'b11, 32'h2468ACE0});
    rst = 1'b1;
    tick();
    check_outputs_zero("midrst");
    tick();
    rst = 1'b0;
    tick();
    chk("rst_release_ready", {AWREADY, WREADY, ARREADY, BVALID, RVALID, oWriteValid, oReadValid},
        7'b1110000);
    quiet = 1;
    for (int i = 0; i < T + 2; i++) begin
      tick();
      if (BVALID || RVALID || oWriteValid || oReadValid) quiet = 0;
    end
    chk("rst_no_response", quiet, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
